// File: rtl/fp_accum_seq.sv
// Initiator-side sequencer for an external fp32 adder: folds LEN elements into
// a running sum through an add_x/add_y/add_z handshake, with a done watchdog.
module fp_accum_seq #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      add_x,
  output logic [31:0]      add_y,
  output logic             add_x_rdy,
  output logic             add_y_rdy,
  input  logic [31:0]      add_z,
  input  logic             add_done,
  output logic [31:0]      acc_data,
  output logic             acc_valid,
  output logic             busy,
  output logic             err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [31:0]      acc_r, acc_nxt_s;
  logic [LEN_W-1:0] remain_r, remain_nxt_s;
  logic [WD_W-1:0]  wd_r, wd_nxt_s;
  logic             in_ready_r, in_ready_nxt_s;
  logic [31:0]      add_x_r, add_x_nxt_s;
  logic [31:0]      add_y_r, add_y_nxt_s;
  logic             rdy_r, rdy_nxt_s;
  logic [31:0]      acc_data_r, acc_data_nxt_s;
  logic             acc_valid_r, acc_valid_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             err_r, err_nxt_s;
  logic             handshake_s;
  logic             wd_expired_s;

  assign handshake_s  = in_valid && in_ready_r;
  assign wd_expired_s = (wd_r == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (len != {LEN_W{1'b0}}) ? ST_LOAD : ST_FINISH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (handshake_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        if (add_done) begin
          state_nxt_s = ST_RELEASE;
        end else if (wd_expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_RELEASE: begin
        if (!add_done) begin
          state_nxt_s = (remain_r <= LEN_W'(1)) ? ST_FINISH : ST_LOAD;
        end else if (wd_expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    acc_nxt_s       = acc_r;
    remain_nxt_s    = remain_r;
    wd_nxt_s        = wd_r;
    in_ready_nxt_s  = in_ready_r;
    add_x_nxt_s     = add_x_r;
    add_y_nxt_s     = add_y_r;
    rdy_nxt_s       = rdy_r;
    acc_data_nxt_s  = acc_data_r;
    acc_valid_nxt_s = 1'b0;
    err_nxt_s       = err_r;
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        wd_nxt_s = {WD_W{1'b0}};
        if (start) begin
          acc_nxt_s      = 32'h0000_0000;
          remain_nxt_s   = len;
          err_nxt_s      = 1'b0;
          in_ready_nxt_s = (len != {LEN_W{1'b0}});
        end else begin
          in_ready_nxt_s = 1'b0;
        end
      end
      ST_LOAD: begin
        wd_nxt_s = {WD_W{1'b0}};
        if (handshake_s) begin
          add_y_nxt_s    = in_data;
          add_x_nxt_s    = acc_r;
          in_ready_nxt_s = 1'b0;
          rdy_nxt_s      = 1'b1;
        end else begin
          in_ready_nxt_s = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (add_done) begin
          acc_nxt_s = add_z;
          rdy_nxt_s = 1'b0;
          wd_nxt_s  = {WD_W{1'b0}};
        end else if (wd_expired_s) begin
          // Responder is stuck: report the partial sum and give up
          err_nxt_s       = 1'b1;
          rdy_nxt_s       = 1'b0;
          acc_data_nxt_s  = acc_r;
          acc_valid_nxt_s = 1'b1;
          wd_nxt_s        = {WD_W{1'b0}};
        end else begin
          wd_nxt_s = wd_r + WD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!add_done) begin
          wd_nxt_s = {WD_W{1'b0}};
          if (remain_r != {LEN_W{1'b0}}) begin
            remain_nxt_s = remain_r - LEN_W'(1);
          end else begin
            remain_nxt_s = remain_r;
          end
          in_ready_nxt_s = (remain_r > LEN_W'(1));
        end else if (wd_expired_s) begin
          err_nxt_s       = 1'b1;
          rdy_nxt_s       = 1'b0;
          acc_data_nxt_s  = acc_r;
          acc_valid_nxt_s = 1'b1;
          wd_nxt_s        = {WD_W{1'b0}};
        end else begin
          wd_nxt_s = wd_r + WD_W'(1);
        end
      end
      ST_FINISH: begin
        acc_data_nxt_s  = acc_r;
        acc_valid_nxt_s = 1'b1;
        wd_nxt_s        = {WD_W{1'b0}};
      end
      default: begin
        rdy_nxt_s      = 1'b0;
        in_ready_nxt_s = 1'b0;
        wd_nxt_s       = {WD_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= 32'h0000_0000;
      remain_r    <= {LEN_W{1'b0}};
      wd_r        <= {WD_W{1'b0}};
      in_ready_r  <= 1'b0;
      add_x_r     <= 32'h0000_0000;
      add_y_r     <= 32'h0000_0000;
      rdy_r       <= 1'b0;
      acc_data_r  <= 32'h0000_0000;
      acc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      remain_r    <= remain_nxt_s;
      wd_r        <= wd_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      add_x_r     <= add_x_nxt_s;
      add_y_r     <= add_y_nxt_s;
      rdy_r       <= rdy_nxt_s;
      acc_data_r  <= acc_data_nxt_s;
      acc_valid_r <= acc_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign add_x     = add_x_r;
  assign add_y     = add_y_r;
  assign add_x_rdy = rdy_r;
  assign add_y_rdy = rdy_r;
  assign acc_data  = acc_data_r;
  assign acc_valid = acc_valid_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq: a reactive adder responder, a fold-based
// reference sum, table-driven vectors, random sums and directed corner sequences.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] add_x, add_y, add_z;
  logic        add_x_rdy, add_y_rdy, add_done;
  logic [31:0] acc_data;
  logic        acc_valid, busy, err;

  int checks = 0;
  int errors = 0;

  int resp_lat  = 4;
  int resp_hold = 0;
  bit resp_dead = 1'b0;
  int r_cnt     = 0;
  int r_hold    = 0;

  fp_accum_seq #(.LEN_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_x(add_x), .add_y(add_y), .add_x_rdy(add_x_rdy), .add_y_rdy(add_y_rdy),
    .add_z(add_z), .add_done(add_done),
    .acc_data(acc_data), .acc_valid(acc_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // External adder: exact fp32 results for the directed operands, an
  // order-sensitive scramble for everything else.
  function automatic logic [31:0] adder_fn(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000;
      {32'h0000_0000, 32'h4000_0000}: return 32'h4000_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4040_0000, 32'h4040_0000}: return 32'h40C0_0000;
      default: return {x[15:0], x[31:16]} ^ (y + 32'h9E37_79B9);
    endcase
  endfunction

  // Reference: the final sum is the left fold of the adder over the stream
  function automatic logic [31:0] ref_sum(input int n, input logic [7:0][31:0] el);
    logic [31:0] a = 32'h0000_0000;
    for (int i = 0; i < n; i++) a = adder_fn(a, el[i]);
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Responder: raise done after resp_lat cycles of rdy, keep it resp_hold
  // cycles after rdy drops, and poison add_z once rdy is gone.
  initial begin
    add_done = 1'b0;
    add_z    = 32'h0000_0000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        add_done = 1'b0;
        r_cnt    = 0;
      end else if (add_done) begin
        if (!add_x_rdy) begin
          add_z = 32'hDEAD_BEEF;
          if (r_hold <= 0) add_done = 1'b0;
          else r_hold--;
        end
      end else if (add_x_rdy && !resp_dead) begin
        r_cnt++;
        if (r_cnt >= resp_lat) begin
          add_z    = adder_fn(add_x, add_y);
          add_done = 1'b1;
          r_cnt    = 0;
          r_hold   = resp_hold;
        end
      end
    end
  end

  task automatic run_sum(input string nm, input int n, input logic [7:0][31:0] el,
                         input int gap, input int lat, input int hold,
                         input bit pulse, input logic [31:0] exp);
    int idx = 0, cyc = 1, nvalid = 0, overlap = 0, busy_after = 0, valid_at = -1;
    bit hs_pend = 1'b0, fin = 1'b0;
    logic [31:0] got = 32'h0;
    logic got_err = 1'b0;
    resp_lat = lat; resp_hold = hold; resp_dead = 1'b0;
    @(negedge clk);
    start = 1'b1; len = n[7:0]; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".busy_start"}, 32'(busy), 32'd1);
    chk({nm, ".ready_start"}, 32'(in_ready), 32'(n != 0));
    while (!fin && cyc < 3000) begin
      if (hs_pend) idx++;
      if (acc_valid) begin
        nvalid++; got = acc_data; got_err = err; valid_at = cyc; fin = 1'b1;
        chk({nm, ".busy_at_valid"}, 32'(busy), 32'd0);
      end
      if (in_ready && add_done) overlap++;
      in_valid = (idx < n) && (cyc % gap == 0);
      in_data  = in_valid ? el[idx] : $urandom;
      start    = pulse && (cyc == 3);
      if (start) len = 8'd7;
      hs_pend  = in_valid && in_ready;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({nm, ".finished"}, 32'(fin), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (acc_valid) nvalid++;
      if (busy) busy_after++;
      @(negedge clk);
    end
    chk({nm, ".sum"}, got, exp);
    chk({nm, ".valid_pulses"}, 32'(nvalid), 32'd1);
    chk({nm, ".err"}, 32'(got_err), 32'd0);
    chk({nm, ".accepted"}, 32'(idx), 32'(n));
    chk({nm, ".ready_during_done"}, 32'(overlap), 32'd0);
    chk({nm, ".busy_after"}, 32'(busy_after), 32'd0);
    if (n == 0) chk({nm, ".valid_latency"}, 32'(valid_at), 32'd2);
  endtask

  typedef struct {
    string            nm;
    int               n;
    logic [7:0][31:0] el;
    int               gap;
    int               lat;
    int               hold;
    bit               pulse;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [5];
  logic [7:0][31:0] s123;
  logic [7:0][31:0] s2;
  logic [7:0][31:0] rel;

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_data = 32'h0; in_valid = 1'b0;
    s123 = '0; s123[0] = 32'h3F80_0000; s123[1] = 32'h4000_0000; s123[2] = 32'h4040_0000;
    s2 = '0; s2[0] = 32'h4000_0000;
    vecs[0] = '{"sum123",   3, s123, 1, 4, 0,  1'b0, 32'h40C0_0000};
    vecs[1] = '{"len0",     0, s123, 1, 4, 0,  1'b0, 32'h0000_0000};
    vecs[2] = '{"gap_start",3, s123, 5, 2, 0,  1'b1, 32'h40C0_0000};
    vecs[3] = '{"hold10",   3, s123, 1, 3, 10, 1'b0, 32'h40C0_0000};
    vecs[4] = '{"one",      1, s2,   1, 1, 0,  1'b0, 32'h4000_0000};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {in_ready, add_x_rdy, add_y_rdy, acc_valid, busy, err}, 32'd0);
    chk("reset_acc_data", acc_data, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_sum(vecs[v].nm, vecs[v].n, vecs[v].el, vecs[v].gap, vecs[v].lat,
              vecs[v].hold, vecs[v].pulse, vecs[v].exp);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) rel[i] = $urandom;
      run_sum("random", n, rel, $urandom_range(1, 4), $urandom_range(1, 5),
              $urandom_range(0, 3), 1'b0, ref_sum(n, rel));
    end

    // Dead responder: watchdog fires 64 cycles after rdy rises
    begin
      int c1 = -1, c2 = -1, cyc = 0;
      logic [31:0] snap_data = 32'h0;
      logic snap_valid = 1'b0, snap_rdy = 1'b1, snap_busy = 1'b1;
      resp_dead = 1'b1;
      @(negedge clk); start = 1'b1; len = 8'd2;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
      while (c2 < 0 && cyc < 300) begin
        @(negedge clk); cyc++;
        if (add_x_rdy && c1 < 0) begin c1 = cyc; in_valid = 1'b0; end
        if (err && c2 < 0) begin
          c2 = cyc; snap_data = acc_data; snap_valid = acc_valid;
          snap_rdy = add_x_rdy | add_y_rdy; snap_busy = busy;
        end
      end
      in_valid = 1'b0;
      chk("timeout.seen", 32'(c2 >= 0 && c1 >= 0), 32'd1);
      chk("timeout.latency", 32'(c2 - c1), 32'd64);
      chk("timeout.acc_data", snap_data, 32'h0);
      chk("timeout.acc_valid", 32'(snap_valid), 32'd1);
      chk("timeout.rdy", 32'(snap_rdy), 32'd0);
      chk("timeout.busy", 32'(snap_busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("timeout.sticky", 32'(err), 32'd1);
      resp_dead = 1'b0;
    end
    run_sum("after_timeout", 1, s2, 1, 2, 0, 1'b0, 32'h4000_0000);

    // Reset during the issue phase of the second element
    begin
      int rises = 0, cyc = 0;
      logic prev = 1'b0;
      resp_lat = 20; resp_hold = 0;
      @(negedge clk); start = 1'b1; len = 8'd3;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
      while (rises < 2 && cyc < 300) begin
        @(negedge clk); cyc++;
        if (add_x_rdy && !prev) rises++;
        prev = add_x_rdy;
      end
      chk("rst.reached_issue2", 32'(rises), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("rst.flags", {in_ready, add_x_rdy, add_y_rdy, acc_valid, busy, err}, 32'd0);
      chk("rst.add_x", add_x, 32'h0);
      chk("rst.add_y", add_y, 32'h0);
      chk("rst.acc_data", acc_data, 32'h0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.no_valid", 32'(acc_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
    end
    run_sum("after_reset", 1, s2, 1, 4, 0, 1'b0, 32'h4000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
